// File: rtl/key_event_pkg.sv
// Shared definitions for the key event detector: FSM state encoding and
// default cycle counts for the 50 MHz system clock.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 20 ms debounce window at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;
    // 2 s long-press threshold at 50 MHz
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RESET_VAL sets the level both flops take during reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the raw input through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_event_detector.sv
// Button conditioner: synchronizes and debounces a raw button input, and
// produces a debounced level plus single-cycle press/release pulses.
// Optional long-press detection is built when KEY_EVENT_LONG_PRESS_EN is
// defined; otherwise long_press_pulse is tied low.
module key_event_detector
    import key_event_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int unsigned      DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          btn_sync;
    logic          s;
    key_state_t    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          press_d, release_d, level_d;

    // synchronizer idles at the released level so reset never looks like a press
    sync_2ff #(
        .RESET_VAL(ACTIVE_LOW)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_in),
        .q    (btn_sync)
    );

    assign s = btn_sync ^ ACTIVE_LOW;

    // next-state, debounce counter and event decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // state register and registered level/pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

`ifdef KEY_EVENT_LONG_PRESS_EN
    localparam int unsigned      HW        = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

    logic [HW-1:0] hold_q, hold_d;
    logic          done_q, done_d;
    logic          long_d;

    // hold timer: runs only in PRESSED, frozen through release bounces
    always_comb begin
        hold_d = hold_q;
        done_d = done_q;
        long_d = 1'b0;
        if (state_q == IDLE && s) begin
            hold_d = '0;
        end
        if (state_q == PRESSED) begin
            if (hold_q == HOLD_LAST && !done_q) begin
                long_d = 1'b1;
                done_d = 1'b1;
            end
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HW'(1);
            end
        end
        if (state_q != IDLE && state_d == IDLE) begin
            done_d = 1'b0;
        end
    end

    // hold timer, per-press done flag and long-press output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q           <= '0;
            done_q           <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            hold_q           <= hold_d;
            done_q           <= done_d;
            long_press_pulse <= long_d;
        end
    end
`else
    assign long_press_pulse = 1'b0;

    // keeps LONG_PRESS_CYCLES referenced while the feature is compiled out
    if (LONG_PRESS_CYCLES == 0) begin : g_long_unused
    end
`endif

endmodule

// File: doc/key_event_detector.md
# key_event_detector

Conditions a raw, asynchronous push-button or contact input into clean, single-cycle event pulses and a debounced level. It sits directly upstream of `pulse_stretcher`: `press_pulse` (or `long_press_pulse`) drives that block's `pulse_in` for visible LED feedback. It also feeds the command/control logic that needs one event per physical press.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000 — consecutive stable cycles required to accept a level change (20 ms @ 50 MHz); legal range ≥1.
- `LONG_PRESS_CYCLES`, default 100_000_000 — cycles held in PRESSED before a long-press event (2 s @ 50 MHz); legal range ≥1.
- `ACTIVE_LOW`, default 1 — 1: raw input low = pressed; 0: raw high = pressed.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_in`  in  1  raw asynchronous button input; may bounce.
- `btn_level`  out  1  debounced state, active-high pressed.
- `press_pulse`  out  1  one-cycle pulse on each accepted press.
- `release_pulse`  out  1  one-cycle pulse on each accepted release.
- `long_press_pulse`  out  1  one-cycle pulse, at most once per press.

## Operation
- `btn_in` passes through a 2-FF synchronizer, then is normalized by `ACTIVE_LOW` to `s` (1 = pressed).
- The synchronizer resets to the released level.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. A debounce counter is cleared on every state entry.
  - IDLE: `s`=1 → PRESS_WAIT.
  - PRESS_WAIT: `s`=0 → IDLE (no event). `cnt`==DEBOUNCE_CYCLES-1 → PRESSED, and `press_pulse` is registered high. Otherwise `cnt`++.
  - PRESSED: `s`=0 → RELEASE_WAIT.
  - RELEASE_WAIT: `s`=1 → PRESSED (no event). `cnt`==DEBOUNCE_CYCLES-1 → IDLE, and `release_pulse` is registered high. Otherwise `cnt`++.
- `btn_level` = 1 in PRESSED and RELEASE_WAIT. It is registered and changes on the same edge as the matching pulse.
- Hold counter:
  - Cleared on the IDLE→PRESS_WAIT transition.
  - Increments only in PRESSED and saturates at LONG_PRESS_CYCLES.
  - Frozen, not cleared, during RELEASE_WAIT, so a release bounce does not restart the long-press timing.
- Long press: when the hold counter reaches LONG_PRESS_CYCLES-1 in PRESSED, `long_press_pulse` is high for one cycle. A per-press done flag blocks repeats and is cleared on entering IDLE.
- Counter widths are $clog2(param+1). No wrap-around is possible: the debounce counter is cleared on every state entry, and the hold counter saturates.
- All outputs are registered; there are no combinational paths from `btn_in`.

## Timing
- Reset (async assert): state IDLE, counters 0, done flag 0, all four outputs 0.
- After reset release with the button held: a normal press is reported after the standard latency. No pulse is generated by reset itself.
- Press latency: let E0 be the edge that first samples the new raw level into FF1. `press_pulse` is high for exactly the one cycle following edge E(DEBOUNCE_CYCLES+2), and `btn_level` rises at that edge.
- Release latency is identical.
- Glitches shorter than DEBOUNCE_CYCLES cycles at `s` produce no event and no change of `btn_level`.
- Back-to-back: `press_pulse` and `release_pulse` are never high together. They are separated by at least DEBOUNCE_CYCLES+1 cycles.
- `long_press_pulse` is high for the one cycle following the edge at which PRESSED has been occupied for LONG_PRESS_CYCLES cycles, counted from the cycle `press_pulse` is high and excluding RELEASE_WAIT cycles.
- If `s` drops on the same edge the long threshold is reached, the long pulse still fires (it is evaluated in PRESSED), and the FSM moves to RELEASE_WAIT.

## Configuration
- Macro `KEY_EVENT_LONG_PRESS_EN`.
- Defined: hold counter, done flag and `long_press_pulse` logic are present as described above.
- Undefined: that logic is omitted, `long_press_pulse` is tied to 0, and `LONG_PRESS_CYCLES` is ignored. The port list is unchanged.

## Structure
- Shared package `key_event_pkg`:
  - FSM state encodings (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3).
  - Default cycle constants for the 50 MHz system clock.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with a parameterized reset value. It is reused elsewhere for other asynchronous inputs.

## Test plan
Use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1.
- Reset, `btn_in`=1 held → all outputs 0 for 50 cycles.
- `btn_in` 1→0 and held → `press_pulse` high exactly one cycle after E6; `btn_level` rises at E6; no other pulses.
- After press, `btn_in` toggles 0/1 with high glitches of 1–3 cycles for 40 cycles, then settles at 1 → no events during the glitches; a single `release_pulse` 6 edges after the final settle; `btn_level` falls on the same edge.
- Press held for 100 cycles, with the macro defined → exactly one `long_press_pulse`, 20 cycles after `press_pulse`. With the macro undefined → `long_press_pulse` stays 0.
- Release bounce of 2 cycles at PRESSED cycle 10 → no `release_pulse`; `long_press_pulse` arrives 22 cycles after `press_pulse`.
- `rst_n` asserted while PRESSED with the button held → outputs 0 immediately. After deassertion, `press_pulse` fires 6 edges later.
